// File: rtl/cycle_timer_pkg.sv
// cycle_timer_pkg: shared types and constants for the machine timer.
//   mtime_t            64-bit time / compare value
//   *_OFS              byte offsets of the four 32-bit registers
//   CMP_RESET_DEFAULT  reset value of mtimecmp (never fires until written)
//   word_ofs()         strips the ignored byte-lane bits from a bus address
package cycle_timer_pkg;

  typedef logic [63:0] mtime_t;

  localparam logic [3:0] MTIME_LO_OFS = 4'h0;
  localparam logic [3:0] MTIME_HI_OFS = 4'h4;
  localparam logic [3:0] CMP_LO_OFS   = 4'h8;
  localparam logic [3:0] CMP_HI_OFS   = 4'hC;

  localparam mtime_t CMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  // Registers are word aligned; addr[1:0] carries no information.
  function automatic logic [3:0] word_ofs(input logic [3:0] addr);
    return addr & 4'hC;
  endfunction

endpackage

// File: rtl/cycle_timer_if.sv
// cycle_timer_if: peripheral data bus between the core (master) and the timer (slave).
//   req    access request, one cycle per access
//   we     write enable, qualified by req
//   addr   byte offset, addr[1:0] ignored
//   wdata  write data
//   rdata  read data, valid while ack is high, 0 otherwise and on write acks
//   ack    one-cycle acknowledge
// Handshake: there is no ready/backpressure. Every cycle with req=1 is one
// accepted access, and ack=1 exactly one cycle later. Back-to-back requests
// produce back-to-back acks.
interface cycle_timer_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cycle_timer_timebase_extend.sv
// timebase_extend: widens the free-running 32-bit hardware cycle count to a
// 64-bit mtime by counting the wraps of the count.
//   clk, rst  clock, asynchronous active-high reset
//   hc_in     32-bit free-running count
//   mtime     {hi_q, lo_q}; lo_q lags hc_in by one cycle
module timebase_extend
  import cycle_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hc_in,
  output mtime_t      mtime
);

  logic [31:0] lo_q;
  logic [31:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= hc_in;
      // Wrap detect: upper half to lower half of the count. A reset of the
      // upstream counter from below 2^31 is therefore not mistaken for a wrap.
      if (lo_q[31] && !hc_in[31]) begin
        hi_q <= hi_q + 32'd1;
      end
    end
  end

  assign mtime = {hi_q, lo_q};

endmodule

// File: rtl/cycle_timer.sv
// cycle_timer: memory-mapped machine timer.
//   clk, rst  clock, asynchronous active-high reset
//   hc_in     free-running 32-bit cycle count from the hardware counter
//   bus       peripheral bus slave (cycle_timer_if.slave)
//   irq       level timer interrupt, registered (mtime >= mtimecmp)
// Register map: 0x0 MTIME_LO (RO, snapshots hi), 0x4 MTIME_HI (RO, snapshot),
// 0x8 CMP_LO (RW), 0xC CMP_HI (RW). Writes to read-only offsets are acked and dropped.
module cycle_timer
  import cycle_timer_pkg::*;
#(
  parameter mtime_t CMP_RESET = CMP_RESET_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   hc_in,
  cycle_timer_if.slave  bus,
  output logic          irq
);

  mtime_t      mtime;
  mtime_t      mtimecmp;
  logic [31:0] hi_snap;
  logic [3:0]  reg_ofs;

  timebase_extend u_timebase (
    .clk   (clk),
    .rst   (rst),
    .hc_in (hc_in),
    .mtime (mtime)
  );

  assign reg_ofs = word_ofs(bus.addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp  <= CMP_RESET;
      hi_snap   <= '0;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      irq       <= 1'b0;
    end else begin
      // Compare uses the pre-edge mtimecmp, so a CMP write shows in irq one
      // edge after the register itself changes.
      irq       <= (mtime >= mtimecmp);
      bus.ack   <= bus.req;
      bus.rdata <= '0;
      if (bus.req) begin
        if (bus.we) begin
          case (reg_ofs)
            CMP_LO_OFS: mtimecmp[31:0]  <= bus.wdata;
            CMP_HI_OFS: mtimecmp[63:32] <= bus.wdata;
            default:    ;
          endcase
        end else begin
          case (reg_ofs)
            MTIME_LO_OFS: begin
              // Freeze the upper half seen alongside this lower half so a
              // following MTIME_HI read forms a coherent 64-bit pair.
              bus.rdata <= mtime[31:0];
              hi_snap   <= mtime[63:32];
            end
            MTIME_HI_OFS: bus.rdata <= hi_snap;
            CMP_LO_OFS:   bus.rdata <= mtimecmp[31:0];
            CMP_HI_OFS:   bus.rdata <= mtimecmp[63:32];
            default:      bus.rdata <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cycle_timer.sv
module tb_cycle_timer;
  import cycle_timer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] hc_in = 32'd0;
  logic        irq;

  cycle_timer_if bus();

  cycle_timer #(.CMP_RESET(CMP_RESET_DEFAULT)) dut (
    .clk   (clk),
    .rst   (rst),
    .hc_in (hc_in),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Time is a 64-bit number whose low word is last cycle's count and whose
  // high word counts how often the count fell from the upper half of its
  // range into the lower half.
  logic [31:0] mdl_lo, mdl_hi, mdl_snap, mdl_rdata;
  logic [63:0] mdl_cmp;
  logic        mdl_irq, mdl_ack;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    mdl_lo = 0; mdl_hi = 0; mdl_snap = 0; mdl_rdata = 0;
    mdl_cmp = CMP_RESET_DEFAULT; mdl_irq = 0; mdl_ack = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hxxxx_xxxx;
    return exp_q.pop_front();
  endfunction

  // One clock edge: the model evaluates with the inputs in place, then the
  // counter advances like a free-running source.
  task automatic step();
    logic [63:0] now_t, nxt_cmp;
    logic [31:0] nxt_rdata, nxt_snap;
    logic        nxt_irq, nxt_ack, wrapped;
    now_t     = {mdl_hi, mdl_lo};
    nxt_irq   = (now_t >= mdl_cmp);
    nxt_ack   = bus.req;
    nxt_rdata = 0;
    nxt_snap  = mdl_snap;
    nxt_cmp   = mdl_cmp;
    if (bus.req) begin
      if (bus.we) begin
        if (bus.addr[3:2] == 2'd2) nxt_cmp[31:0] = bus.wdata;
        else if (bus.addr[3:2] == 2'd3) nxt_cmp[63:32] = bus.wdata;
      end else begin
        case (bus.addr[3:2])
          2'd0: begin nxt_rdata = mdl_lo; nxt_snap = mdl_hi; end
          2'd1: nxt_rdata = mdl_snap;
          2'd2: nxt_rdata = mdl_cmp[31:0];
          default: nxt_rdata = mdl_cmp[63:32];
        endcase
        exp_q.push_back(nxt_rdata);
      end
    end
    wrapped = (mdl_lo >= 32'h8000_0000) && (hc_in < 32'h8000_0000);
    @(posedge clk);
    #1;
    mdl_irq = nxt_irq; mdl_ack = nxt_ack; mdl_rdata = nxt_rdata;
    mdl_snap = nxt_snap; mdl_cmp = nxt_cmp;
    if (wrapped) mdl_hi = mdl_hi + 32'd1;
    mdl_lo = hc_in;
    hc_in = hc_in + 32'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
  endtask

  task automatic do_reset(input logic [31:0] hc);
    bus_idle();
    hc_in = hc;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic got_ack, output logic [31:0] got_data);
    bus.req = 1; bus.we = 0; bus.addr = a; bus.wdata = $urandom;
    step();
    got_ack = bus.ack; got_data = bus.rdata;
    bus_idle();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output logic got_ack, output logic [31:0] got_data);
    bus.req = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
    step();
    got_ack = bus.ack; got_data = bus.rdata;
    bus_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic a; logic [31:0] d;
    do_reset(32'd5);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (bus.ack !== 1'b0 || bus.rdata !== 32'd0) begin
      errors++; $display("FAIL reset_bus got ack=%b rdata=%h exp ack=0 rdata=0", bus.ack, bus.rdata); end
    step();
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL idle_ack got %b exp 0", bus.ack); end
    bus_read(CMP_LO_OFS, a, d);
    checks++; if (a !== 1'b1 || d !== 32'hFFFF_FFFF || d !== pop_exp()) begin
      errors++; $display("FAIL reset_cmp_lo got ack=%b data=%h exp ack=1 data=ffffffff", a, d); end
    step();
    checks++; if (bus.ack !== 1'b0 || bus.rdata !== 32'd0) begin
      errors++; $display("FAIL ack_one_cycle got ack=%b rdata=%h exp 0 0", bus.ack, bus.rdata); end
    bus_read(CMP_HI_OFS, a, d);
    checks++; if (a !== 1'b1 || d !== 32'hFFFF_FFFF || d !== pop_exp()) begin
      errors++; $display("FAIL reset_cmp_hi got ack=%b data=%h exp ack=1 data=ffffffff", a, d); end
  endtask

  task automatic test_wrap();
    logic a; logic [31:0] d;
    do_reset(32'd5);
    hc_in = 32'hFFFF_FFFE;
    repeat (4) step();   // presents FFFFFFFE, FFFFFFFF, 0, 1
    bus_read(MTIME_LO_OFS, a, d);
    checks++; if (a !== 1'b1 || d !== 32'd1 || d !== pop_exp()) begin
      errors++; $display("FAIL wrap_lo got ack=%b data=%h exp ack=1 data=1", a, d); end
    bus_read(MTIME_HI_OFS, a, d);
    checks++; if (a !== 1'b1 || d !== 32'd1 || d !== pop_exp()) begin
      errors++; $display("FAIL wrap_hi got ack=%b data=%h exp ack=1 data=1", a, d); end
  endtask

  task automatic test_snapshot();
    logic a; logic [31:0] d;
    do_reset(32'd5);
    for (int i = 0; i < 3; i++) begin
      hc_in = 32'hFFFF_FFFE;
      repeat (3) step();
    end
    hc_in = 32'hFFFF_FFFE;
    repeat (2) step();   // lo = FFFFFFFF, hi = 3, hc_in = 0 presented now
    bus_read(MTIME_LO_OFS, a, d);
    checks++; if (d !== 32'hFFFF_FFFF || d !== pop_exp()) begin
      errors++; $display("FAIL snap_lo got %h exp ffffffff", d); end
    bus_read(MTIME_HI_OFS, a, d);
    checks++; if (d !== 32'd3 || d !== pop_exp()) begin
      errors++; $display("FAIL snap_hi got %h exp 3", d); end
    repeat (3) step();
    bus_read(MTIME_HI_OFS, a, d);
    checks++; if (d !== 32'd3 || d !== pop_exp()) begin
      errors++; $display("FAIL snap_hi_stale got %h exp 3", d); end
    bus_read(MTIME_LO_OFS, a, d);
    void'(pop_exp());
    bus_read(MTIME_HI_OFS, a, d);
    checks++; if (d !== 32'd4 || d !== pop_exp()) begin
      errors++; $display("FAIL snap_hi_new got %h exp 4", d); end
  endtask

  task automatic test_compare();
    logic a; logic [31:0] d;
    do_reset(32'd5);
    bus_write(CMP_HI_OFS, 32'd0, a, d);
    checks++; if (a !== 1'b1 || d !== 32'd0) begin
      errors++; $display("FAIL cmp_hi_write_ack got ack=%b rdata=%h exp 1 0", a, d); end
    bus_write(CMP_LO_OFS, 32'd100, a, d);
    hc_in = 32'd90;
    for (int k = 0; k < 15; k++) begin
      step();   // step k presented hc_in = 90 + k
      checks++; if (irq !== (k >= 11) || irq !== mdl_irq) begin
        errors++; $display("FAIL cmp_rise k=%0d got %b exp %b", k, irq, (k >= 11)); end
    end
  endtask

  task automatic test_clear();
    logic a; logic [31:0] d;
    hc_in = 32'd150;
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clear_pre got %b exp 1", irq); end
    bus_write(CMP_LO_OFS, 32'd1000, a, d);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clear_old_cmp got %b exp 1", irq); end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_after got %b exp 0", irq); end
    bus_write(CMP_LO_OFS, 32'd0, a, d);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rearm_old_cmp got %b exp 0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rearm got %b exp 1", irq); end
  endtask

  task automatic test_back_to_back();
    logic a; logic [31:0] d, lo_before;
    logic [3:0] seq [4];
    seq[0] = MTIME_LO_OFS; seq[1] = MTIME_HI_OFS; seq[2] = CMP_LO_OFS; seq[3] = CMP_HI_OFS;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.req = 1; bus.we = 0; bus.addr = seq[i];
      step();
      checks++; if (bus.ack !== 1'b1 || bus.rdata !== pop_exp()) begin
        errors++; $display("FAIL b2b_%0d got ack=%b data=%h exp ack=1 data=%h", i, bus.ack, bus.rdata, mdl_rdata); end
    end
    bus_idle();
    step();
    checks++; if (bus.ack !== 1'b0 || bus.rdata !== 32'd0) begin
      errors++; $display("FAIL b2b_end got ack=%b rdata=%h exp 0 0", bus.ack, bus.rdata); end
    bus_write(MTIME_LO_OFS, 32'hDEAD_BEEF, a, d);
    checks++; if (a !== 1'b1 || d !== 32'd0) begin
      errors++; $display("FAIL ro_write_ack got ack=%b rdata=%h exp 1 0", a, d); end
    lo_before = mdl_lo;
    bus_read(MTIME_LO_OFS, a, d);
    checks++; if (d !== lo_before || d === 32'hDEAD_BEEF || d !== pop_exp()) begin
      errors++; $display("FAIL ro_write_effect got %h exp %h", d, lo_before); end
  endtask

  task automatic test_reset_mid_access();
    logic a; logic [31:0] d;
    bus_write(CMP_HI_OFS, 32'd0, a, d);
    bus_write(CMP_LO_OFS, 32'd0, a, d);
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_pre_irq got %b exp 1", irq); end
    bus.req = 1; bus.we = 0; bus.addr = CMP_LO_OFS;
    @(posedge clk);
    rst = 1;
    bus_idle();
    #1;
    checks++; if (bus.ack !== 1'b0 || bus.rdata !== 32'd0) begin
      errors++; $display("FAIL mid_ack got ack=%b rdata=%h exp 0 0", bus.ack, bus.rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
    do_reset(hc_in);
    step();
    checks++; if (bus.ack !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL mid_after got ack=%b irq=%b exp 0 0", bus.ack, irq); end
  endtask

  task automatic test_random();
    logic last_read;
    int sel;
    logic [31:0] e;
    do_reset($urandom);
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 99);
      bus_idle();
      last_read = 0;
      if (sel < 35) begin
        bus.req = 1; bus.we = 0; bus.addr = 4'($urandom_range(0, 15));
        last_read = 1;
      end else if (sel < 50) begin
        bus.req = 1; bus.we = 1; bus.addr = 4'($urandom_range(0, 15));
        if (bus.addr[3:2] == 2'd3) bus.wdata = mdl_hi + 32'($urandom_range(0, 1));
        else bus.wdata = mdl_lo + 32'($urandom_range(0, 60));
      end else if (sel < 53) begin
        hc_in = $urandom_range(0, 1000);          // upstream counter reset
      end else if (sel < 56) begin
        hc_in = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else if (sel < 58) begin
        hc_in = 32'h7FFF_FFF8 + 32'($urandom_range(0, 15));
      end
      step();
      checks++; if (irq !== mdl_irq || bus.ack !== mdl_ack) begin
        errors++; $display("FAIL rand_%0d got irq=%b ack=%b exp irq=%b ack=%b", n, irq, bus.ack, mdl_irq, mdl_ack); end
      e = last_read ? pop_exp() : 32'd0;
      checks++; if (bus.rdata !== e) begin
        errors++; $display("FAIL rand_data_%0d got %h exp %h", n, bus.rdata, e); end
    end
    bus_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_idle();
    model_reset();
    test_reset();
    test_wrap();
    test_snapshot();
    test_compare();
    test_clear();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
